// File: rtl/audio_nios_irq_ctrl_if.sv
// Avalon-MM slave bus bundle for the audio interrupt aggregator.
// The master drives the address, strobes and write data; the slave returns registered read data.
interface audio_nios_irq_ctrl_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/audio_nios_irq_ctrl.sv
// Interrupt aggregator: latches audio peripheral irqs as pending, masks them and drives one
// registered irq plus the lowest active source ID. Define INTC_IRQ_SYNC_EN to add a 2-flop input sync.
module audio_nios_irq_ctrl #(
  parameter int               N_IRQ    = 8,
  parameter logic [N_IRQ-1:0] EDGE_RST = {N_IRQ{1'b1}}
) (
  input  logic                 clk,
  input  logic                 reset_n,
  audio_nios_irq_ctrl_if.slave bus,
  input  logic [N_IRQ-1:0]     irq_in,
  output logic                 irq_out,
  output logic [3:0]           irq_id
);

  localparam logic [2:0] ADDR_STATUS   = 3'd0;
  localparam logic [2:0] ADDR_MASK     = 3'd1;
  localparam logic [2:0] ADDR_EDGE_SEL = 3'd2;
  localparam logic [2:0] ADDR_RAW      = 3'd3;
  localparam logic [2:0] ADDR_ACTIVE   = 3'd4;
  localparam logic [2:0] ADDR_SOFT_SET = 3'd5;

  logic [N_IRQ-1:0] irq_s;
  logic [N_IRQ-1:0] irq_prev_q;
  logic [N_IRQ-1:0] pending_q, pending_d;
  logic [N_IRQ-1:0] mask_q, mask_d;
  logic [N_IRQ-1:0] edge_sel_q, edge_sel_d;
  logic [N_IRQ-1:0] rise, set_v, clr_v, act;
  logic [N_IRQ-1:0] wdata;
  logic [15:0]      readdata_q, readdata_d;
  logic             irq_out_q, irq_out_d;
  logic [3:0]       irq_id_q, irq_id_d;
  logic             wr_en, status_wr, mask_wr, edge_wr, soft_wr;

`ifdef INTC_IRQ_SYNC_EN
  logic [N_IRQ-1:0] sync1_q, sync2_q;

  // Sources from the codec clock domain are brought in through two flops before edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_in;
      sync2_q <= sync1_q;
    end
  end

  assign irq_s = sync2_q;
`else
  assign irq_s = irq_in;
`endif

  assign wdata     = bus.writedata[N_IRQ-1:0];
  assign wr_en     = bus.chipselect & ~bus.write_n;
  assign status_wr = wr_en & (bus.address == ADDR_STATUS);
  assign mask_wr   = wr_en & (bus.address == ADDR_MASK);
  assign edge_wr   = wr_en & (bus.address == ADDR_EDGE_SEL);
  assign soft_wr   = wr_en & (bus.address == ADDR_SOFT_SET);

  assign mask_d     = mask_wr ? wdata : mask_q;
  assign edge_sel_d = edge_wr ? wdata : edge_sel_q;

  // A set condition beats a simultaneous W1C so a still-asserted level source cannot be lost.
  genvar gi;
  generate
    for (gi = 0; gi < N_IRQ; gi++) begin : g_pend
      assign rise[gi]      = irq_s[gi] & ~irq_prev_q[gi];
      assign set_v[gi]     = (edge_sel_q[gi] ? rise[gi] : irq_s[gi]) | (soft_wr & wdata[gi]);
      assign clr_v[gi]     = status_wr & wdata[gi];
      assign pending_d[gi] = set_v[gi] ? 1'b1 : (clr_v[gi] ? 1'b0 : pending_q[gi]);
    end
  endgenerate

  assign act = pending_q & mask_q;

  always_comb begin
    irq_out_d = |act;
    irq_id_d  = 4'd0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (act[i]) irq_id_d = 4'(i);
    end
  end

  // ACTIVE reads the registered irq_out/irq_id pair so software always sees a consistent view.
  always_comb begin
    readdata_d = '0;
    case (bus.address)
      ADDR_STATUS:   readdata_d[N_IRQ-1:0] = pending_q;
      ADDR_MASK:     readdata_d[N_IRQ-1:0] = mask_q;
      ADDR_EDGE_SEL: readdata_d[N_IRQ-1:0] = edge_sel_q;
      ADDR_RAW:      readdata_d[N_IRQ-1:0] = irq_s;
      ADDR_ACTIVE:   readdata_d = {irq_out_q, 11'b0, irq_id_q};
      default:       readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_prev_q <= '0;
      pending_q  <= '0;
      mask_q     <= '0;
      edge_sel_q <= EDGE_RST;
      readdata_q <= '0;
      irq_out_q  <= 1'b0;
      irq_id_q   <= 4'd0;
    end else begin
      irq_prev_q <= irq_s;
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      edge_sel_q <= edge_sel_d;
      readdata_q <= readdata_d;
      irq_out_q  <= irq_out_d;
      irq_id_q   <= irq_id_d;
    end
  end

  assign bus.readdata = readdata_q;
  assign irq_out      = irq_out_q;
  assign irq_id       = irq_id_q;

endmodule

// File: tb/tb_audio_nios_irq_ctrl.sv
// Directed bench for audio_nios_irq_ctrl: register reads go through an expected-value queue,
// irq_out/irq_id are checked directly after each directed step.
module tb_audio_nios_irq_ctrl;
`ifdef INTC_IRQ_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic       clk;
  logic       reset_n;
  logic [7:0] irq_in;
  logic       irq_out;
  logic [3:0] irq_id;

  int n_assert;
  int n_fail;

  logic [15:0] exp_q[$];
  string       tag_q[$];

  audio_nios_irq_ctrl_if bus_if ();

  audio_nios_irq_ctrl #(.N_IRQ(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if),
    .irq_in  (irq_in),
    .irq_out (irq_out),
    .irq_id  (irq_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_irq(input string tag, input logic exp_out, input logic [3:0] exp_id);
    check({tag, "_irq_out"}, {15'b0, irq_out}, {15'b0, exp_out});
    check({tag, "_irq_id"}, {12'b0, irq_id}, {12'b0, exp_id});
  endtask

  task automatic bus_read(input string tag, input logic [2:0] addr, input logic [15:0] exp);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    bus_if.address    = addr;
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b1;
    tick();
    bus_if.chipselect = 1'b0;
    check(tag_q.pop_front(), bus_if.readdata, exp_q.pop_front());
  endtask

  task automatic bus_write(input logic [2:0] addr, input logic [15:0] data);
    bus_if.address    = addr;
    bus_if.writedata  = data;
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b0;
    tick();
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    bus_if.writedata  = 16'h0000;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    irq_in   = 8'h00;
    bus_if.address    = 3'd0;
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    bus_if.writedata  = 16'h0000;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    // 1: reset values
    check_irq("rst", 1'b0, 4'd0);
    bus_read("rst_status", 3'd0, 16'h0000);
    bus_read("rst_mask", 3'd1, 16'h0000);
    bus_read("rst_edge", 3'd2, 16'h00FF);
    bus_read("rst_raw", 3'd3, 16'h0000);
    bus_read("rst_active", 3'd4, 16'h0000);
    bus_read("rst_soft", 3'd5, 16'h0000);
    bus_read("rst_a6", 3'd6, 16'h0000);
    bus_read("rst_a7", 3'd7, 16'h0000);

    // 2: single source, latency, W1C
    bus_write(3'd1, 16'h0001);
    irq_in = 8'h01;
    tick();
    irq_in = 8'h00;
    repeat (LAT - 2) tick();
    check_irq("t2_early", 1'b0, 4'd0);
    tick();
    check_irq("t2_lat", 1'b1, 4'd0);
    bus_read("t2_active", 3'd4, 16'h8000);
    bus_read("t2_status", 3'd0, 16'h0001);
    bus_write(3'd0, 16'h0001);
    check_irq("t2_clr1", 1'b1, 4'd0);
    tick();
    check_irq("t2_clr2", 1'b0, 4'd0);
    bus_read("t2_status_clr", 3'd0, 16'h0000);

    // 3: priority of lowest index
    bus_write(3'd1, 16'h00FF);
    irq_in = 8'h24;
    tick();
    irq_in = 8'h00;
    repeat (LAT) tick();
    check_irq("t3_id2", 1'b1, 4'd2);
    bus_write(3'd0, 16'h0004);
    tick();
    check_irq("t3_id5", 1'b1, 4'd5);
    bus_read("t3_active", 3'd4, 16'h8005);
    bus_write(3'd0, 16'h0020);
    tick();
    check_irq("t3_none", 1'b0, 4'd0);

    // 4: level mode re-sets while source held
    bus_write(3'd2, 16'h00FE);
    bus_read("t4_edge", 3'd2, 16'h00FE);
    irq_in = 8'h01;
    repeat (LAT) tick();
    bus_read("t4_raw", 3'd3, 16'h0001);
    bus_write(3'd0, 16'h0001);
    bus_read("t4_held", 3'd0, 16'h0001);
    irq_in = 8'h00;
    repeat (LAT) tick();
    bus_write(3'd0, 16'h0001);
    bus_read("t4_dropped", 3'd0, 16'h0000);
    tick();
    check_irq("t4_irq", 1'b0, 4'd0);

    // 5: masked source still latches
    bus_write(3'd1, 16'h0000);
    irq_in = 8'h08;
    tick();
    irq_in = 8'h00;
    repeat (LAT) tick();
    bus_read("t5_status", 3'd0, 16'h0008);
    check_irq("t5_masked", 1'b0, 4'd0);
    bus_write(3'd1, 16'h0008);
    tick();
    check_irq("t5_unmask", 1'b1, 4'd3);
    bus_read("t5_active", 3'd4, 16'h8003);
    bus_write(3'd0, 16'h0008);

    // 6: soft set, set-vs-clear priority, async reset
    bus_write(3'd5, 16'h0010);
    bus_read("t6_soft", 3'd0, 16'h0010);
    bus_read("t6_soft_rd", 3'd5, 16'h0000);
    bus_write(3'd0, 16'h0010);
    bus_read("t6_b2b_clr", 3'd0, 16'h0000);
    bus_write(3'd5, 16'h0010);
    irq_in = 8'h10;
    repeat (LAT - 2) tick();
    bus_write(3'd0, 16'h0010);
    irq_in = 8'h00;
    bus_read("t6_setwins", 3'd0, 16'h0010);
    bus_write(3'd1, 16'h00FF);
    tick();
    check_irq("t6_pre_rst", 1'b1, 4'd4);
    reset_n = 1'b0;
    #2;
    check_irq("t6_rst", 1'b0, 4'd0);
    check("t6_rst_rdata", bus_if.readdata, 16'h0000);
    tick();
    reset_n = 1'b1;
    tick();
    bus_read("t6_status", 3'd0, 16'h0000);
    bus_read("t6_mask", 3'd1, 16'h0000);
    bus_read("t6_edge", 3'd2, 16'h00FF);
    check_irq("t6_after", 1'b0, 4'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
